mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the IF-stage instruction fetch and the MEM-stage load/store.
- Sequences each access with a req/ack handshake, with a fairness guard and a timeout watchdog.
- Produces per-stage stall signals. These drive the pipeline stall inputs, which are currently tied FALSE.

Parameters:
W, 32, data/address width (`WORD_WIDTH)
BE_W, 4, byte-enable width (W/8)
STREAK_MAX, 4, max consecutive data grants while a fetch waits
TIMEOUT, 255, cycles in a grant state without m_ack before abort (>=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-low reset
if_req  in  1  fetch request, level, held until if_done
if_addr  in  W  fetch address, stable while if_req
if_rdata  out  W  fetched word, valid with if_done, held until next fetch response
if_done  out  1  one-cycle response pulse
d_req  in  1  data request, level, held until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  W  data address
d_wdata  in  W  store data
d_be  in  BE_W  byte enables
d_rdata  out  W  load data, valid with d_done, held until next load response
d_done  out  1  one-cycle response pulse
m_req  out  1  memory request, held until m_ack or abort
m_we  out  1  memory write
m_addr  out  W  memory address
m_wdata  out  W  memory write data
m_be  out  BE_W  memory byte enables
m_ack  in  1  one-cycle ack; m_rdata valid in the same cycle
m_rdata  in  W  memory read data
err  out  1  pulses with done when the access timed out
stall_if  out  1  if_req & ~if_done
stall_mem  out  1  d_req & ~d_done
busy  out  1  state != IDLE

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE; m_req, m_we, if_done, d_done and err go to 0.
  - m_addr, m_wdata, m_be, if_rdata and d_rdata go to 0.
  - The streak and timeout counters clear.
  - Reset mid-access abandons the access; a later stray m_ack is ignored.
- States:
  - IDLE: requests are sampled here only.
  - GNT_IF / GNT_D: m_req=1 and the m_* fields are frozen.
  - RESP: one cycle; the selected done is 1, then return to IDLE.
- IDLE arbitration:
  - Only d_req: go to GNT_D.
  - Only if_req: go to GNT_IF.
  - Both: GNT_D, unless streak==STREAK_MAX, in which case GNT_IF.
  - The grant edge registers addr/we/wdata/be into m_*. m_we=0 and m_be all ones for a fetch.
- Streak counter:
  - On a GNT_D entry with if_req high: increment, saturating at STREAK_MAX.
  - On a GNT_D entry with if_req low: clear.
  - On a GNT_IF entry: clear.
- In a grant state, when m_ack=1:
  - Next edge: m_req goes to 0 and the state goes to RESP.
  - A load or fetch captures m_rdata into d_rdata/if_rdata.
  - A store leaves d_rdata unchanged.
- Timeout: the counter runs in grant states from 0.
  - On the cycle count==TIMEOUT-1 with m_ack=0: drop m_req and go to RESP with err=1.
  - The rdata of the aborted access reads 0.
  - m_ack and expiry in the same cycle: ack wins, err=0.
- Latency:
  - Request seen in IDLE at cycle N; m_req first high at N+1.
  - Ack at N+1+k (k>=0); done at N+2+k. The minimum round trip is 3 cycles.
- Requester obligations:
  - req is not sampled during RESP.
  - A requester drops req or presents a new request after its done; a still-high req in the following IDLE cycle is a new request.
- m_ack in IDLE or RESP is ignored.
- stall_* are combinational from req/done.
- busy is registered-state derived.

Decomposition:
- Shared defines/package: the ARB_IDLE/ARB_GNT_IF/ARB_GNT_D/ARB_RESP encodings, ARB_STATE_W=2, BE_W, and the default TIMEOUT and STREAK_MAX.
- One sub-module: mem_arb_watchdog. It is the timeout counter with clear/enable and an expire output, parameterised by TIMEOUT.

Test Plan:
- Lone fetch: if_req with if_addr=0x100, ack on the 2nd cycle of m_req with m_rdata=0x24020005 -> m_addr=0x100 and m_we=0; if_done pulses 1 cycle after ack; if_rdata=0x24020005; err=0.
- Simultaneous requests: if_req and d_req (store to 0x200, data 0xAABBCCDD, be=0xF) in the same IDLE cycle -> data granted first with m_we=1; fetch granted at the next IDLE; stall_if high throughout.
- Fairness: fetch held with back-to-back d_req, immediate ack, STREAK_MAX=4 -> 4 data grants, then the 5th grant is the fetch; streak clears.
- Timeout: d_req load with m_ack never asserted, TIMEOUT=8 -> m_req high exactly 8 cycles; d_done and err pulse together; d_rdata=0. Repeat with ack on the expiry cycle -> err=0 and data is captured.
- Reset mid-access: rst=0 during GNT_D, then a stray m_ack after release -> all outputs 0, state IDLE, no done pulse.
- Store leaves d_rdata: a load returning 0x12345678, then a store -> d_rdata stays 0x12345678 after the store's d_done.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings and default sizing for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int ARB_STATE_W    = 2;
  localparam int DEF_W          = 32;
  localparam int DEF_BE_W       = DEF_W / 8;
  localparam int DEF_TIMEOUT    = 255;
  localparam int DEF_STREAK_MAX = 4;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_IF = 2'd1,
    ARB_GNT_D  = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_e;

  function automatic logic is_grant(input arb_state_e s);
    return (s == ARB_GNT_IF) || (s == ARB_GNT_D);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side request/response and memory-side bus signals of the arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int BE_W = DEF_BE_W
);
  logic            if_req;
  logic [W-1:0]    if_addr;
  logic [W-1:0]    if_rdata;
  logic            if_done;
  logic            d_req;
  logic            d_we;
  logic [W-1:0]    d_addr;
  logic [W-1:0]    d_wdata;
  logic [BE_W-1:0] d_be;
  logic [W-1:0]    d_rdata;
  logic            d_done;
  logic            m_req;
  logic            m_we;
  logic [W-1:0]    m_addr;
  logic [W-1:0]    m_wdata;
  logic [BE_W-1:0] m_be;
  logic            m_ack;
  logic [W-1:0]    m_rdata;
  logic            err;
  logic            stall_if;
  logic            stall_mem;
  logic            busy;

  // master: the arbiter itself; slave: pipeline stages plus memory
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata,
    output if_rdata, if_done, d_rdata, d_done, m_req, m_we, m_addr, m_wdata, m_be,
           err, stall_if, stall_mem, busy
  );
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ack, m_rdata,
    input  if_rdata, if_done, d_rdata, d_done, m_req, m_we, m_addr, m_wdata, m_be,
           err, stall_if, stall_mem, busy
  );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Grant-state timeout counter: counts from 0 while enabled, flags the last allowed cycle.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with a
// data-streak fairness guard and a grant timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int BE_W       = DEF_BE_W,
  parameter int STREAK_MAX = DEF_STREAK_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.master bus
);
  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_CAP = SW'(STREAK_MAX);

  arb_state_e      state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [W-1:0]    m_addr_q, m_addr_d;
  logic [W-1:0]    m_wdata_q, m_wdata_d;
  logic [BE_W-1:0] m_be_q, m_be_d;
  logic [W-1:0]    if_rdata_q, if_rdata_d;
  logic [W-1:0]    d_rdata_q, d_rdata_d;
  logic            if_done_q, if_done_d;
  logic            d_done_q, d_done_d;
  logic            err_q, err_d;
  logic            wd_en, wd_expire, fetch_starved;

  assign wd_en = is_grant(state_q);
  assign fetch_starved = bus.if_req && (streak_q == STREAK_CAP);

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!wd_en),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_be_d     = m_be_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (bus.d_req && !fetch_starved) begin
          state_d   = ARB_GNT_D;
          m_req_d   = 1'b1;
          m_we_d    = bus.d_we;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          m_be_d    = bus.d_be;
          if (!bus.if_req)
            streak_d = '0;
          else if (streak_q != STREAK_CAP)
            streak_d = streak_q + 1'b1;
        end else if (bus.if_req) begin
          state_d  = ARB_GNT_IF;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = bus.if_addr;
          m_be_d   = '1;
          streak_d = '0;
        end
      end
      ARB_GNT_IF, ARB_GNT_D: begin
        // ack takes priority over expiry when both land in the same cycle
        if (bus.m_ack || wd_expire) begin
          state_d = ARB_RESP;
          m_req_d = 1'b0;
          err_d   = !bus.m_ack;
          if (state_q == ARB_GNT_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.m_ack ? bus.m_rdata : '0;
          end else begin
            d_done_d = 1'b1;
            if (!bus.m_ack)
              d_rdata_d = '0;
            else if (!m_we_q)
              d_rdata_d = bus.m_rdata;
          end
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      streak_q   <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_be_q     <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_be_q     <= m_be_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      err_q      <= err_d;
    end
  end

  assign bus.m_req     = m_req_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_be      = m_be_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.err       = err_q;
  assign bus.stall_if  = bus.if_req & ~if_done_q;
  assign bus.stall_mem = bus.d_req & ~d_done_q;
  assign bus.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Transaction-level bench: a requester/memory driver plus a grant-order and
// response model derived from the arbitration, fairness and timeout rules.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int W    = 32;
  localparam int BE_W = 4;
  localparam int TMO  = 8;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.W(W), .BE_W(BE_W)) bus ();

  mem_port_arbiter #(.W(W), .BE_W(BE_W), .STREAK_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // model state: data grants in a row while a fetch waited, and last responses
  int        streak_m = 0;
  logic [W-1:0] exp_if_rdata = '0;
  logic [W-1:0] exp_d_rdata  = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [W-1:0] addr);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
  endtask

  task automatic set_data(input logic we, input logic [W-1:0] addr,
                          input logic [W-1:0] wdata, input logic [BE_W-1:0] be);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_be    = be;
  endtask

  // Called in an IDLE cycle with requests already presented. Ack comes k
  // cycles after m_req rises; k >= TMO means the memory never answers.
  task automatic run_txn(input int k, input logic [W-1:0] rdata);
    logic use_d, exp_we, acked;
    logic [W-1:0] exp_addr, exp_wdata;
    logic [BE_W-1:0] exp_be;
    if (bus.d_req && bus.if_req) use_d = (streak_m != SMAX);
    else use_d = bus.d_req;
    if (use_d) streak_m = bus.if_req ? ((streak_m < SMAX) ? streak_m + 1 : SMAX) : 0;
    else streak_m = 0;
    exp_we    = use_d ? bus.d_we : 1'b0;
    exp_addr  = use_d ? bus.d_addr : bus.if_addr;
    exp_be    = use_d ? bus.d_be : '1;
    exp_wdata = bus.d_wdata;
    step();
    check_val("gnt_m_req", 64'(bus.m_req), 64'd1);
    check_val("gnt_busy", 64'(bus.busy), 64'd1);
    check_val("gnt_m_addr", 64'(bus.m_addr), 64'(exp_addr));
    check_val("gnt_m_we", 64'(bus.m_we), 64'(exp_we));
    check_val("gnt_m_be", 64'(bus.m_be), 64'(exp_be));
    if (use_d) check_val("gnt_m_wdata", 64'(bus.m_wdata), 64'(exp_wdata));
    check_val("gnt_stall_if", 64'(bus.stall_if), 64'(bus.if_req));
    check_val("gnt_stall_mem", 64'(bus.stall_mem), 64'(bus.d_req));
    acked = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      if (c == k) begin
        bus.m_ack   = 1'b1;
        bus.m_rdata = rdata;
        step();
        bus.m_ack   = 1'b0;
        bus.m_rdata = $urandom;
        acked = 1'b1;
        break;
      end
      step();
      if (c == TMO - 1) break;
      check_val("hold_m_req", 64'(bus.m_req), 64'd1);
      check_val("hold_m_addr", 64'(bus.m_addr), 64'(exp_addr));
    end
    if (acked) begin
      if (!use_d) exp_if_rdata = rdata;
      else if (!exp_we) exp_d_rdata = rdata;
    end else begin
      if (!use_d) exp_if_rdata = '0;
      else exp_d_rdata = '0;
    end
    check_val("resp_if_done", 64'(bus.if_done), 64'(!use_d));
    check_val("resp_d_done", 64'(bus.d_done), 64'(use_d));
    check_val("resp_err", 64'(bus.err), 64'(!acked));
    check_val("resp_m_req", 64'(bus.m_req), 64'd0);
    check_val("resp_if_rdata", 64'(bus.if_rdata), 64'(exp_if_rdata));
    check_val("resp_d_rdata", 64'(bus.d_rdata), 64'(exp_d_rdata));
    check_val("resp_stall_if", 64'(bus.stall_if), 64'(bus.if_req && use_d));
    check_val("resp_stall_mem", 64'(bus.stall_mem), 64'(bus.d_req && !use_d));
    $display("txn %s addr=0x%08h we=%0d k=%0d err=%0d if_rdata=0x%08h d_rdata=0x%08h",
             use_d ? "DATA " : "FETCH", exp_addr, exp_we, k, !acked, bus.if_rdata, bus.d_rdata);
    if (use_d) bus.d_req = 1'b0;
    else bus.if_req = 1'b0;
    step();
    check_val("idle_busy", 64'(bus.busy), 64'd0);
    check_val("idle_dones", 64'({bus.if_done, bus.d_done, bus.err}), 64'd0);
    check_val("idle_if_rdata", 64'(bus.if_rdata), 64'(exp_if_rdata));
    check_val("idle_d_rdata", 64'(bus.d_rdata), 64'(exp_d_rdata));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctl"}, 64'({bus.m_req, bus.m_we, bus.if_done, bus.d_done, bus.err, bus.busy}), 64'd0);
    check_val({tag, "_m_addr"}, 64'(bus.m_addr), 64'd0);
    check_val({tag, "_m_wdata"}, 64'(bus.m_wdata), 64'd0);
    check_val({tag, "_m_be"}, 64'(bus.m_be), 64'd0);
    check_val({tag, "_if_rdata"}, 64'(bus.if_rdata), 64'd0);
    check_val({tag, "_d_rdata"}, 64'(bus.d_rdata), 64'd0);
  endtask

  initial begin
    int r, k;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    rst = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b1;
    step();

    // lone fetch, ack on the second m_req cycle
    set_fetch(32'h100);
    run_txn(1, 32'h24020005);

    // simultaneous store and fetch: data first, then the fetch
    set_fetch(32'h104);
    set_data(1'b1, 32'h200, 32'hAABBCCDD, 4'hF);
    run_txn(0, 32'h0BADBEEF);
    run_txn(0, 32'h11111111);

    // fairness: fetch held while data keeps coming back
    set_fetch(32'h400);
    for (int i = 0; i < 5; i++) begin
      if (!bus.d_req) set_data(1'b0, 32'h500 + 32'(i * 4), 32'h0, 4'h3);
      run_txn(0, 32'hD0000000 + 32'(i));
    end
    run_txn(0, 32'h55AA55AA);

    // timeout, then ack landing exactly on the expiry cycle
    set_data(1'b0, 32'h300, 32'h0, 4'hF);
    run_txn(TMO, 32'hFFFFFFFF);
    set_data(1'b0, 32'h304, 32'h0, 4'hF);
    run_txn(TMO - 1, 32'hCAFEF00D);

    // a store must not disturb the last load data
    set_data(1'b0, 32'h600, 32'h0, 4'hF);
    run_txn(0, 32'h12345678);
    set_data(1'b1, 32'h604, 32'h9999AAAA, 4'h5);
    run_txn(2, 32'hDEADDEAD);

    // reset in the middle of a data grant, then a stray ack
    set_data(1'b0, 32'h700, 32'h0, 4'hF);
    step();
    check_val("mid_m_req", 64'(bus.m_req), 64'd1);
    rst = 1'b0;
    bus.d_req = 1'b0;
    step();
    rst = 1'b1;
    bus.m_ack = 1'b1;
    bus.m_rdata = 32'h77777777;
    step();
    bus.m_ack = 1'b0;
    check_all_zero("post_rst");
    step();
    check_all_zero("post_rst2");
    streak_m = 0;
    exp_if_rdata = '0;
    exp_d_rdata = '0;

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      if (!bus.if_req && $urandom_range(0, 1) == 1) set_fetch($urandom);
      if (!bus.d_req && $urandom_range(0, 1) == 1)
        set_data(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (!bus.if_req && !bus.d_req) set_fetch($urandom);
      r = $urandom_range(0, 9);
      if (r < 6) k = r % 3;
      else if (r < 9) k = $urandom_range(3, TMO - 1);
      else k = TMO;
      run_txn(k, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
